// File: rtl/npu_tile_scheduler.sv
// Tile scheduler for the NPU: walks a rows x cols grid in row-major order,
// handing one tile at a time to the tile processor and tracking errors.
`timescale 1ns/1ps
module npu_tile_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rows,
    input  logic [2:0] cmd_cols,
    input  logic       abort,
    output logic       tp_start,
    output logic [2:0] tp_tile_i,
    output logic [2:0] tp_tile_j,
    output logic [2:0] tp_op_code,
    input  logic       tp_done,
    output logic       busy,
    output logic       sched_done,
    output logic       err_badop,
    output logic       err_timeout,
    output logic [6:0] tiles_done
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    rows_q, rows_d;
    logic [2:0]    cols_q, cols_d;
    logic [2:0]    i_q, i_d;
    logic [2:0]    j_q, j_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [6:0]    tiles_q, tiles_d;
    logic          badop_q, badop_d;
    logic          tmo_q, tmo_d;
    logic          bad_pulse_q, bad_pulse_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        i_d         = i_q;
        j_d         = j_q;
        timer_d     = timer_q;
        tiles_d     = tiles_q;
        badop_d     = badop_q;
        tmo_d       = tmo_q;
        bad_pulse_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rows_d  = cmd_rows;
                    cols_d  = cmd_cols;
                    i_d     = 3'd0;
                    j_d     = 3'd0;
                    tiles_d = 7'd0;
                    tmo_d   = 1'b0;
                    if (cmd_op > 3'd4) begin
                        badop_d     = 1'b1;
                        bad_pulse_d = 1'b1;
                    end else begin
                        badop_d = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion has priority over the terminal count.
                if (tp_done) begin
                    tiles_d = tiles_q + 7'd1;
                    state_d = S_NEXT;
                end else if (timer_q == TLAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (j_q < cols_q) begin
                    j_d     = j_q + 3'd1;
                    state_d = S_ISSUE;
                end else if (i_q < rows_q) begin
                    j_d     = 3'd0;
                    i_d     = i_q + 3'd1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Abort freezes flags and the tile count where they stand.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tmo_d   = tmo_q;
            tiles_d = tiles_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            rows_q      <= 3'd0;
            cols_q      <= 3'd0;
            i_q         <= 3'd0;
            j_q         <= 3'd0;
            timer_q     <= '0;
            tiles_q     <= 7'd0;
            badop_q     <= 1'b0;
            tmo_q       <= 1'b0;
            bad_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            i_q         <= i_d;
            j_q         <= j_d;
            timer_q     <= timer_d;
            tiles_q     <= tiles_d;
            badop_q     <= badop_d;
            tmo_q       <= tmo_d;
            bad_pulse_q <= bad_pulse_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign tp_start    = (state_q == S_ISSUE);
    assign tp_tile_i   = i_q;
    assign tp_tile_j   = j_q;
    assign tp_op_code  = op_q;
    assign sched_done  = (state_q == S_FINISH) || (state_q == S_ERROR) || bad_pulse_q;
    assign err_badop   = badop_q;
    assign err_timeout = tmo_q;
    assign tiles_done  = tiles_q;

endmodule

// File: tb/tb_npu_tile_scheduler.sv
// Scoreboard bench for npu_tile_scheduler: expected tile starts are queued
// when a command is sent and checked as the scheduler issues them.
`timescale 1ns/1ps
module tb_npu_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [2:0] cmd_rows = 3'd0;
    logic [2:0] cmd_cols = 3'd0;
    logic       abort = 1'b0;
    logic       tp_done = 1'b0;
    logic       cmd_ready, tp_start, busy, sched_done;
    logic       err_badop, err_timeout;
    logic [2:0] tp_tile_i, tp_tile_j, tp_op_code;
    logic [6:0] tiles_done;

    npu_tile_scheduler #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_rows(cmd_rows),
        .cmd_cols(cmd_cols),
        .abort(abort),
        .tp_start(tp_start),
        .tp_tile_i(tp_tile_i),
        .tp_tile_j(tp_tile_j),
        .tp_op_code(tp_op_code),
        .tp_done(tp_done),
        .busy(busy),
        .sched_done(sched_done),
        .err_badop(err_badop),
        .err_timeout(err_timeout),
        .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int sched_cnt = 0;
    int start_cnt = 0;
    logic [8:0] exp_q[$];

    int   resp_delay = 0;
    int   resp_limit = 0;
    int   answered = 0;
    int   resp_cnt = 0;
    logic resp_level = 1'b0;

    // Monitor: pops the scoreboard on every tile start.
    always @(negedge clk) begin : mon
        logic [8:0] e;
        if (sched_done) sched_cnt++;
        if (tp_start) begin
            start_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL tile_start: got unexpected op=%0d i=%0d j=%0d, required no start",
                         tp_op_code, tp_tile_i, tp_tile_j);
            end else begin
                e = exp_q.pop_front();
                if ({tp_op_code, tp_tile_i, tp_tile_j} !== e) begin
                    miscompares++;
                    $display("FAIL tile_start: got op=%0d i=%0d j=%0d, required op=%0d i=%0d j=%0d",
                             tp_op_code, tp_tile_i, tp_tile_j, e[8:6], e[5:3], e[2:0]);
                end
            end
        end
    end

    // Tile-processor model: pulse after resp_delay cycles, or hold a level.
    initial begin
        forever begin
            @(negedge clk);
            tp_done = resp_level;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) tp_done = 1'b1;
            end
            if (tp_start && resp_delay > 0 && answered < resp_limit) begin
                resp_cnt = resp_delay;
                answered++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] r,
                            input logic [2:0] c, input int n_exp);
        int k;
        @(negedge clk);
        cmd_op = op;
        cmd_rows = r;
        cmd_cols = c;
        cmd_valid = 1'b1;
        k = 0;
        for (int i = 0; i <= int'(r); i++)
            for (int j = 0; j <= int'(c); j++) begin
                if (k < n_exp) exp_q.push_back({op, 3'(i), 3'(j)});
                k++;
            end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name, output int cyc);
        cyc = 0;
        while (busy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL %s_idle: got busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_reset();
        logic [21:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {tp_start, tp_tile_i, tp_tile_j, tp_op_code, busy, sched_done,
               err_badop, err_timeout, tiles_done, cmd_ready};
        vectors++;
        if (got !== 22'd1) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required %h", got, 22'd1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        resp_delay = 5;
        resp_limit = 1000;
        answered = 0;
        sched_cnt = 0;
        send_cmd(3'd0, 3'd1, 3'd1, 64);
        wait_idle(200, "basic", cyc);
        vectors++;
        if (cyc !== 29) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d, required %0d", cyc, 29);
        end
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL basic_starts: got %0d missing, required 0", exp_q.size());
        end
        vectors++;
        if (tiles_done !== 7'd4) begin
            miscompares++;
            $display("FAIL basic_tiles: got %0d, required 4", tiles_done);
        end
        vectors++;
        if (sched_cnt !== 1) begin
            miscompares++;
            $display("FAIL basic_sched_done: got %0d, required 1", sched_cnt);
        end
        vectors++;
        if ({cmd_ready, err_badop, err_timeout} !== 3'b100) begin
            miscompares++;
            $display("FAIL basic_flags: got %b, required 100",
                     {cmd_ready, err_badop, err_timeout});
        end
    endtask

    task automatic test_badop();
        int s0;
        sched_cnt = 0;
        s0 = start_cnt;
        send_cmd(3'd6, 3'd2, 3'd2, 0);
        vectors++;
        if ({err_badop, sched_done, cmd_ready, busy} !== 4'b1110) begin
            miscompares++;
            $display("FAIL badop_accept: got %b, required 1110",
                     {err_badop, sched_done, cmd_ready, busy});
        end
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if ({cmd_ready, sched_done} !== 2'b10) begin
                miscompares++;
                $display("FAIL badop_after: got %b, required 10", {cmd_ready, sched_done});
            end
        end
        vectors++;
        if (sched_cnt !== 1 || start_cnt !== s0) begin
            miscompares++;
            $display("FAIL badop_pulses: got sched=%0d starts=%0d, required 1 and 0",
                     sched_cnt, start_cnt - s0);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        resp_delay = 5;
        resp_limit = 1;
        answered = 0;
        sched_cnt = 0;
        send_cmd(3'd1, 3'd0, 3'd2, 2);
        wait_idle(200, "timeout", cyc);
        vectors++;
        if (cyc !== 25) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d, required %0d", cyc, 25);
        end
        vectors++;
        if ({err_timeout, err_badop, tiles_done} !== {2'b10, 7'd1}) begin
            miscompares++;
            $display("FAIL timeout_flags: got tmo=%b bad=%b tiles=%0d, required 1 0 1",
                     err_timeout, err_badop, tiles_done);
        end
        vectors++;
        if (sched_cnt !== 1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL timeout_pulses: got sched=%0d pending=%0d, required 1 0",
                     sched_cnt, exp_q.size());
        end
    endtask

    task automatic test_level();
        int cyc;
        resp_delay = 0;
        resp_level = 1'b1;
        sched_cnt = 0;
        @(negedge clk);
        send_cmd(3'd4, 3'd7, 3'd7, 64);
        wait_idle(400, "level", cyc);
        resp_level = 1'b0;
        vectors++;
        if (cyc !== 193) begin
            miscompares++;
            $display("FAIL level_latency: got %0d, required %0d", cyc, 193);
        end
        vectors++;
        if ({err_timeout, tiles_done} !== {1'b0, 7'd64}) begin
            miscompares++;
            $display("FAIL level_tiles: got tmo=%b tiles=%0d, required 0 64",
                     err_timeout, tiles_done);
        end
        vectors++;
        if (sched_cnt !== 1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL level_pulses: got sched=%0d pending=%0d, required 1 0",
                     sched_cnt, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int k;
        int n;
        int cyc;
        resp_delay = 5;
        resp_limit = 1000;
        answered = 0;
        sched_cnt = 0;
        repeat (2) @(negedge clk);
        send_cmd(3'd3, 3'd2, 3'd2, 3);
        k = tp_start ? 1 : 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (tp_start) k++;
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if ({busy, cmd_ready, tiles_done} !== {2'b01, 7'd2}) begin
            miscompares++;
            $display("FAIL abort_state: got busy=%b ready=%b tiles=%0d, required 0 1 2",
                     busy, cmd_ready, tiles_done);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (sched_cnt !== 0 || tiles_done !== 7'd2) begin
            miscompares++;
            $display("FAIL abort_quiet: got sched=%0d tiles=%0d, required 0 2",
                     sched_cnt, tiles_done);
        end
        send_cmd(3'd2, 3'd0, 3'd0, 1);
        wait_idle(100, "abort_new", cyc);
        vectors++;
        if (tiles_done !== 7'd1 || sched_cnt !== 1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL abort_newcmd: got tiles=%0d sched=%0d pending=%0d, required 1 1 0",
                     tiles_done, sched_cnt, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] got;
        int cyc;
        resp_delay = 5;
        resp_limit = 1000;
        answered = 0;
        send_cmd(3'd0, 3'd1, 3'd1, 64);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        got = {tp_start, tp_tile_i, tp_tile_j, tp_op_code, busy, sched_done,
               err_badop, err_timeout, tiles_done, cmd_ready};
        vectors++;
        if (got !== 22'd1) begin
            miscompares++;
            $display("FAIL reset_async: got %h, required %h", got, 22'd1);
        end
        exp_q.delete();
        sched_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (sched_cnt !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got sched=%0d busy=%b, required 0 0",
                     sched_cnt, busy);
        end
        send_cmd(3'd1, 3'd0, 3'd0, 1);
        wait_idle(100, "reset_new", cyc);
        vectors++;
        if (tiles_done !== 7'd1 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL reset_newcmd: got tiles=%0d pending=%0d, required 1 0",
                     tiles_done, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_badop();
        test_timeout();
        test_level();
        test_abort();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/npu_tile_scheduler.md
NPU_TILE_SCHEDULER -- requirements
Module: npu_tile_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4096, maximum WAIT-state cycles allowed per tile before a timeout error.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  scheduler can accept a command.
REQ-006 cmd_op  input  3  operation: 0 MUL, 1 ADD, 2 SUB, 3 CONV, 4 DOT; 5-7 illegal.
REQ-007 cmd_rows  input  3  number of tile rows minus 1 (value 0..7 means 1..8 rows).
REQ-008 cmd_cols  input  3  number of tile columns minus 1 (value 0..7 means 1..8 columns).
REQ-009 abort  input  1  synchronous cancel of the running command.
REQ-010 tp_start  output  1  one-cycle start pulse to the tile processor.
REQ-011 tp_tile_i  output  3  tile row index.
REQ-012 tp_tile_j  output  3  tile column index.
REQ-013 tp_op_code  output  3  latched cmd_op.
REQ-014 tp_done  input  1  tile-processor completion; a level or a pulse is accepted.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 sched_done  output  1  one-cycle pulse marking command end: normal, bad-op or timeout.
REQ-017 err_badop  output  1  sticky flag: last command had an illegal op.
REQ-018 err_timeout  output  1  sticky flag: last command timed out.
REQ-019 tiles_done  output  7  tiles completed in the current or last command (0..64).

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, NEXT, FINISH, ERROR; state is held in a register.
REQ-021 cmd_ready = 1 only in IDLE; a command is accepted on the edge where cmd_valid & cmd_ready.
REQ-022 On acceptance, the block latches op, rows and cols, clears err_badop, err_timeout and tiles_done, and sets i = 0 and j = 0.
REQ-023 Acceptance with legal op moves the FSM to ISSUE.
REQ-024 Acceptance with op > 4 sets err_badop, pulses sched_done on the next cycle, and keeps the FSM in IDLE; no tp_start is issued.
REQ-025 ISSUE lasts exactly 1 cycle with tp_start = 1; the FSM then moves to WAIT and the timer is cleared.
REQ-026 tp_start is 1 only in ISSUE, so the first tp_start occurs in the cycle after acceptance.
REQ-027 tp_tile_i, tp_tile_j and tp_op_code are driven from registers and stay stable from ISSUE through the end of WAIT.
REQ-028 In WAIT, the timer increments every cycle.
REQ-029 In WAIT, tp_done = 1 moves the FSM to NEXT and increments tiles_done (7-bit, no wrap possible).
REQ-030 In WAIT, if the timer reaches TIMEOUT_CYCLES-1 with tp_done = 0, the FSM moves to ERROR.
REQ-031 tp_done and timer terminal count in the same cycle: done wins.
REQ-032 tp_done in IDLE, ISSUE, NEXT, FINISH or ERROR is ignored.
REQ-033 NEXT, 1 cycle, row-major order:
- if j < cols: j++ and go to ISSUE;
- else if i < rows: j = 0, i++ and go to ISSUE;
- else: go to FINISH.
REQ-034 FINISH: sched_done = 1 for 1 cycle, then IDLE.
REQ-035 ERROR: set err_timeout, sched_done = 1 for 1 cycle, then IDLE; tiles_done holds the completed count.
REQ-036 Per-tile overhead is 3 cycles plus the tile-processor latency: ISSUE, minimum 1 WAIT cycle, NEXT.
REQ-037 abort = 1 in any non-IDLE state forces IDLE on the next edge.
REQ-038 On abort, no further tp_start or sched_done is produced; error flags are unchanged and tiles_done holds.
REQ-039 abort in IDLE is ignored; abort together with cmd_valid in IDLE accepts the command.
REQ-040 DOT uses the same iteration as the other ops; tile indices are passed through unchanged.

Reset
REQ-041 While rst_n = 0, the FSM is in IDLE and i, j and the timer are 0.
REQ-042 While rst_n = 0: tp_start = 0, tp_tile_i = 0, tp_tile_j = 0, tp_op_code = 0, busy = 0, sched_done = 0, err_badop = 0, err_timeout = 0, tiles_done = 0, cmd_ready = 1.
REQ-043 Reset asserted mid-command aborts the command immediately; no sched_done is produced after release.

Verification
REQ-044 cmd op = 0, rows = 1, cols = 1; tp_done is returned 5 cycles after each start. Required: four tp_start pulses with (i,j) = (0,0), (0,1), (1,0), (1,1); tiles_done = 4; one sched_done; busy falls together with the FSM returning to IDLE.
REQ-045 cmd op = 6. Required: no tp_start; err_badop = 1; sched_done pulses exactly once; cmd_ready stays 1.
REQ-046 TIMEOUT_CYCLES = 16, cmd rows = 0, cols = 2, tp_done never returned for the second tile. Required: err_timeout = 1 after 16 WAIT cycles; tiles_done = 1; sched_done pulses once.
REQ-047 tp_done held high continuously across tiles. Required: each tile takes exactly 3 cycles; ISSUE-cycle tp_done is not counted; tiles_done equals (rows+1)*(cols+1) for rows = cols = 7 (64).
REQ-048 abort asserted during the WAIT of tile 3 of a 3x3 job. Required: IDLE next cycle; no sched_done; tiles_done = 2; a new command is then accepted normally.
REQ-049 rst_n pulsed low mid-WAIT. Required: all outputs show their reset values asynchronously; no tp_start until a new command is accepted.
